// File: rtl/hcm_access_sequencer_pkg.sv
// Shared parameters, state encoding and helpers for the HCM access sequencer.
package hcm_access_sequencer_pkg;

  localparam int unsigned NREQ             = 4;
  localparam int unsigned ROWINDEXBITS_HCM = 9;
  localparam int unsigned HITINFOBITS      = 16;
  localparam int unsigned DRAIN_CYCLES     = 8;
  localparam int unsigned STALLCNTBITS     = 16;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    DRAIN   = 2'd1,
    READOUT = 2'd2,
    CLEAR   = 2'd3
  } state_e;

  // Saturating increment for the per-requester stall counters.
  function automatic logic [STALLCNTBITS-1:0] sat_inc(input logic [STALLCNTBITS-1:0] v);
    return (&v) ? v : v + STALLCNTBITS'(1);
  endfunction

endpackage

// File: rtl/hcm_access_sequencer_rr_arbiter.sv
// hcm_rr_arbiter: N-way round-robin winner search with a pointer that advances
// past the winner only when the grant is actually consumed.
module hcm_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  valid,
  input  logic          advance,
  output logic [IW-1:0] winner_c,
  output logic          found_c
);

  localparam int unsigned IDXW = IW + 1;

  logic [IW-1:0]   ptr;
  logic [IDXW-1:0] idx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + IDXW'(k);
      if (idx >= IDXW'(N)) begin
        idx = idx - IDXW'(N);
      end
      if (valid[idx[IW-1:0]]) begin
        winner_c = idx[IW-1:0];
        found_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found_c) begin
      ptr <= (winner_c == IW'(N - 1)) ? '0 : winner_c + 1'b1;
    end
  end

endmodule

// File: rtl/hcm_access_sequencer.sv
// Per-event HCM access sequencer: arbitrated hit writes, drain, full-row readout, clear.
// Optional per-requester stall counters are built when HCM_SEQ_STALL_COUNT_EN is defined.
module hcm_access_sequencer #(
  parameter int unsigned NREQ             = hcm_access_sequencer_pkg::NREQ,
  parameter int unsigned ROWINDEXBITS_HCM = hcm_access_sequencer_pkg::ROWINDEXBITS_HCM,
  parameter int unsigned HITINFOBITS      = hcm_access_sequencer_pkg::HITINFOBITS,
  parameter int unsigned DRAIN_CYCLES     = hcm_access_sequencer_pkg::DRAIN_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREQ-1:0]                  reqValid,
  input  logic [NREQ*ROWINDEXBITS_HCM-1:0] reqRow,
  input  logic [NREQ-1:0]                  reqSSIDIsNew,
  input  logic [NREQ*HITINFOBITS-1:0]      reqHitInfo,
  output logic [NREQ-1:0]                  reqReady,
  input  logic                             eventEnd,
  input  logic                             hcmStall,
  output logic                             hcmWriteRow,
  output logic                             hcmSSIDIsNew,
  output logic [ROWINDEXBITS_HCM-1:0]      hcmRowToWrite,
  output logic [HITINFOBITS-1:0]           hcmHitInfo,
  output logic                             hcmReadRow,
  output logic [ROWINDEXBITS_HCM-1:0]      hcmRowToRead,
  input  logic                             hcmReadFinished,
  output logic                             hcmReset,
  output logic                             busy,
  output logic                             readoutDone,
  output logic [NREQ*16-1:0]               stallCount
);

  import hcm_access_sequencer_pkg::state_e;
  import hcm_access_sequencer_pkg::ACCEPT;
  import hcm_access_sequencer_pkg::DRAIN;
  import hcm_access_sequencer_pkg::READOUT;
  import hcm_access_sequencer_pkg::CLEAR;

  localparam int unsigned NROWS = 2 ** ROWINDEXBITS_HCM;
  localparam int unsigned CW    = ROWINDEXBITS_HCM + 1;
  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DW    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_e                      state, state_nxt;
  logic [IW-1:0]               winner_c;
  logic                        found_c;
  logic                        transfer_c;
  logic [DW-1:0]               drain_cnt, drain_cnt_nxt;
  logic [CW-1:0]               rd_row, rd_row_nxt;
  logic [CW-1:0]               fin_cnt, fin_cnt_nxt;
  logic                        write_nxt, ssid_nxt, read_nxt, clear_nxt, busy_nxt;
  logic [ROWINDEXBITS_HCM-1:0] wrow_nxt, rrow_nxt;
  logic [HITINFOBITS-1:0]      info_nxt;
  logic                        clear_q;

  hcm_rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    (reqValid),
    .advance  (transfer_c),
    .winner_c (winner_c),
    .found_c  (found_c)
  );

  // eventEnd and stall both veto the grant in the same cycle.
  assign transfer_c = (state == ACCEPT) && !hcmStall && !eventEnd && found_c;
  assign reqReady   = transfer_c ? (NREQ'(1) << winner_c) : '0;

  // Next-state, counters and next values of the registered HCM strobes.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    rd_row_nxt    = rd_row;
    fin_cnt_nxt   = fin_cnt;
    write_nxt     = 1'b0;
    ssid_nxt      = 1'b0;
    wrow_nxt      = hcmRowToWrite;
    info_nxt      = hcmHitInfo;
    read_nxt      = 1'b0;
    rrow_nxt      = hcmRowToRead;
    clear_nxt     = 1'b0;

    case (state)
      ACCEPT: begin
        if (transfer_c) begin
          write_nxt = 1'b1;
          ssid_nxt  = reqSSIDIsNew[winner_c];
          wrow_nxt  = reqRow[winner_c*ROWINDEXBITS_HCM +: ROWINDEXBITS_HCM];
          info_nxt  = reqHitInfo[winner_c*HITINFOBITS +: HITINFOBITS];
        end
        if (eventEnd) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_cnt <= DW'(1)) begin
          state_nxt     = READOUT;
          drain_cnt_nxt = '0;
          rd_row_nxt    = '0;
          fin_cnt_nxt   = '0;
        end else begin
          drain_cnt_nxt = drain_cnt - 1'b1;
        end
      end
      READOUT: begin
        if (!hcmStall && (rd_row < CW'(NROWS))) begin
          read_nxt   = 1'b1;
          rrow_nxt   = rd_row[ROWINDEXBITS_HCM-1:0];
          rd_row_nxt = rd_row + 1'b1;
        end
        if (hcmReadFinished) begin
          fin_cnt_nxt = fin_cnt + 1'b1;
        end
        if (fin_cnt_nxt == CW'(NROWS)) begin
          state_nxt = CLEAR;
          clear_nxt = 1'b1;
        end
      end
      CLEAR: begin
        state_nxt     = ACCEPT;
        drain_cnt_nxt = '0;
        rd_row_nxt    = '0;
        fin_cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ACCEPT;
      end
    endcase

    busy_nxt = (state_nxt != ACCEPT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ACCEPT;
      drain_cnt     <= '0;
      rd_row        <= '0;
      fin_cnt       <= '0;
      hcmWriteRow   <= 1'b0;
      hcmSSIDIsNew  <= 1'b0;
      hcmRowToWrite <= '0;
      hcmHitInfo    <= '0;
      hcmReadRow    <= 1'b0;
      hcmRowToRead  <= '0;
      clear_q       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      drain_cnt     <= drain_cnt_nxt;
      rd_row        <= rd_row_nxt;
      fin_cnt       <= fin_cnt_nxt;
      hcmWriteRow   <= write_nxt;
      hcmSSIDIsNew  <= ssid_nxt;
      hcmRowToWrite <= wrow_nxt;
      hcmHitInfo    <= info_nxt;
      hcmReadRow    <= read_nxt;
      hcmRowToRead  <= rrow_nxt;
      clear_q       <= clear_nxt;
      busy          <= busy_nxt;
    end
  end

  assign hcmReset    = clear_q;
  assign readoutDone = clear_q;

`ifdef HCM_SEQ_STALL_COUNT_EN
  import hcm_access_sequencer_pkg::STALLCNTBITS;
  import hcm_access_sequencer_pkg::sat_inc;

  logic [NREQ-1:0][STALLCNTBITS-1:0] stall_cnt;

  // Count cycles each requester waits with a pending hit; cleared per event.
  always_ff @(posedge clk) begin
    if (reset || clear_q) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (reqValid[i] && !reqReady[i]) begin
          stall_cnt[i] <= sat_inc(stall_cnt[i]);
        end
      end
    end
  end

  assign stallCount = stall_cnt;
`else
  assign stallCount = '0;
`endif

endmodule
